// File: rtl/hs_npu_mem_line_master.sv
// Line-oriented Avalon-MM master for the NPU ordering stage.
// Breaks one NPU line (WORDS_PER_LINE x 32 bit) into single-word Avalon
// beats. At most one read is in flight. A soft abort finishes the beat
// already on the bus and then drops back to IDLE.
// Line layout: word 0 (lowest address) sits in the most significant slot,
// so {w0, w1} on the line ports maps to addresses base, base+4.
module hs_npu_mem_line_master #(
  parameter int WORDS_PER_LINE = 2,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           soft_reset_i,
  input  logic                           read_ready_i,
  input  logic                           write_valid_i,
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic [WORDS_PER_LINE-1:0][31:0] wdata_i,
  output logic [WORDS_PER_LINE-1:0][31:0] rdata_o,
  output logic                           mem_valid_o,
  output logic                           mem_ready_o,
  output logic [ADDR_WIDTH-1:0]          avm_address_o,
  output logic                           avm_read_o,
  output logic                           avm_write_o,
  output logic [31:0]                    avm_writedata_o,
  output logic [3:0]                     avm_byteenable_o,
  input  logic [31:0]                    avm_readdata_i,
  input  logic                           avm_readdatavalid_i,
  input  logic                           avm_waitrequest_i
);
  localparam int KW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, GAP} state_t;

  state_t                          state, state_nxt;
  logic [KW-1:0]                   k, k_nxt;
  logic [ADDR_WIDTH-1:0]           addr_q;
  logic [WORDS_PER_LINE-1:0][31:0] wbuf;      // captured write line
  logic [WORDS_PER_LINE-1:0][31:0] lbuf;      // partially assembled read line
  logic [WORDS_PER_LINE-1:0][31:0] line_nxt;  // lbuf with the arriving word merged in
  logic                            abort_q;   // soft reset seen during this transfer
  logic                            abort;
  logic                            last;
  logic [KW-1:0]                   slot;
  logic [ADDR_WIDTH-1:0]           beat_addr;
  logic                            capture;
  logic                            rd_store;

  assign abort     = abort_q | soft_reset_i;
  assign last      = (k == KW'(WORDS_PER_LINE - 1));
  assign slot      = KW'(WORDS_PER_LINE - 1) - k;
  // modulo 2^ADDR_WIDTH: a line may wrap past the top of the address space
  assign beat_addr = addr_q + (ADDR_WIDTH'(k) << 2);
  assign capture   = (state == IDLE) && !soft_reset_i && (write_valid_i || read_ready_i);
  assign rd_store  = (state == RD_WAIT) && avm_readdatavalid_i && !abort;
  assign mem_ready_o = (state == IDLE) && !soft_reset_i;

  // Merge the returning read word into its slot of the line
  always_comb begin
    line_nxt       = lbuf;
    line_nxt[slot] = avm_readdata_i;
  end

  // Next-state, word counter and Avalon command outputs
  always_comb begin
    state_nxt        = state;
    k_nxt            = k;
    avm_read_o       = 1'b0;
    avm_write_o      = 1'b0;
    avm_address_o    = '0;
    avm_writedata_o  = '0;
    avm_byteenable_o = '0;
    case (state)
      IDLE: begin
        if (!soft_reset_i) begin
          if (write_valid_i)     state_nxt = WR_REQ;
          else if (read_ready_i) state_nxt = RD_REQ;
        end
      end
      RD_REQ: begin
        avm_read_o    = 1'b1;
        avm_address_o = beat_addr;
        // an accepted read must still have its data drained, abort or not
        if (!avm_waitrequest_i) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (avm_readdatavalid_i) begin
          if (abort)     state_nxt = IDLE;
          else if (last) state_nxt = GAP;
          else begin
            state_nxt = RD_REQ;
            k_nxt     = k + 1'b1;
          end
        end
      end
      WR_REQ: begin
        avm_write_o      = 1'b1;
        avm_address_o    = beat_addr;
        avm_writedata_o  = wbuf[slot];
        avm_byteenable_o = 4'hF;
        if (!avm_waitrequest_i) begin
          if (abort)     state_nxt = IDLE;
          else if (last) state_nxt = GAP;
          else           k_nxt     = k + 1'b1;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == IDLE || state_nxt == GAP) k_nxt = '0;
  end

  // State, counter and abort flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      k       <= k_nxt;
      abort_q <= (state_nxt == IDLE) ? 1'b0 : (abort_q | soft_reset_i);
    end
  end

  // Request capture and read-line assembly; rdata_o moves only on a full line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wbuf        <= '0;
      lbuf        <= '0;
      rdata_o     <= '0;
      mem_valid_o <= 1'b0;
    end else begin
      mem_valid_o <= 1'b0;
      if (capture) begin
        addr_q <= addr_i;
        if (write_valid_i) wbuf <= wdata_i;
      end
      if (rd_store) begin
        lbuf <= line_nxt;
        if (last) begin
          rdata_o     <= line_nxt;
          mem_valid_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hs_npu_mem_line_master.sv
// Directed bench for hs_npu_mem_line_master with a one-outstanding Avalon
// slave model whose read latency is adjustable.
module tb_hs_npu_mem_line_master;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              soft_reset_i = 1'b0;
  logic              read_ready_i = 1'b0;
  logic              write_valid_i = 1'b0;
  logic [31:0]       addr_i = '0;
  logic [1:0][31:0]  wdata_i = '0;
  logic [1:0][31:0]  rdata_o;
  logic              mem_valid_o, mem_ready_o;
  logic [31:0]       avm_address_o;
  logic              avm_read_o, avm_write_o;
  logic [31:0]       avm_writedata_o;
  logic [3:0]        avm_byteenable_o;
  logic [31:0]       avm_readdata_i;
  logic              avm_readdatavalid_i;
  logic              avm_waitrequest_i = 1'b0;

  int errs = 0;
  int checks = 0;

  hs_npu_mem_line_master #(.WORDS_PER_LINE(2), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .soft_reset_i(soft_reset_i),
    .read_ready_i(read_ready_i), .write_valid_i(write_valid_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .mem_valid_o(mem_valid_o), .mem_ready_o(mem_ready_o),
    .avm_address_o(avm_address_o), .avm_read_o(avm_read_o),
    .avm_write_o(avm_write_o), .avm_writedata_o(avm_writedata_o),
    .avm_byteenable_o(avm_byteenable_o), .avm_readdata_i(avm_readdata_i),
    .avm_readdatavalid_i(avm_readdatavalid_i), .avm_waitrequest_i(avm_waitrequest_i)
  );

  always #5 clk = ~clk;

  // slave memory contents
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h100: return 32'h1111_1111;
      32'h104: return 32'h2222_2222;
      default: return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // slave model and bus logs
  logic        rdv_pend = 1'b0;
  int          rdv_cnt = 0;
  int          lat = 1;
  logic        stray_rdv = 1'b0;
  logic [31:0] rd_word = '0;
  logic [32:0] bus_log[$];   // {is_write, address}
  logic [31:0] wdat_log[$];
  logic [3:0]  be_log[$];
  int          n_valid = 0;
  int          n_both = 0;

  assign avm_readdatavalid_i = (rdv_pend && rdv_cnt == 0) || stray_rdv;
  assign avm_readdata_i      = rd_word;

  always @(posedge clk) begin
    if (rdv_pend) begin
      if (rdv_cnt == 0) rdv_pend <= 1'b0;
      else              rdv_cnt  <= rdv_cnt - 1;
    end
    if (avm_read_o && !avm_waitrequest_i) begin
      rdv_pend <= 1'b1;
      rdv_cnt  <= lat - 1;
      rd_word  <= mem(avm_address_o);
      bus_log.push_back({1'b0, avm_address_o});
    end
    if (avm_write_o && !avm_waitrequest_i) begin
      bus_log.push_back({1'b1, avm_address_o});
      wdat_log.push_back(avm_writedata_o);
      be_log.push_back(avm_byteenable_o);
    end
    if (avm_read_o && avm_write_o) n_both <= n_both + 1;
    if (mem_valid_o) n_valid <= n_valid + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    bus_log.delete();
    wdat_log.delete();
    be_log.delete();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!mem_valid_o && n < 50) begin tick(); n++; end
    chk({tag, "_valid_seen"}, 64'(mem_valid_o), 64'd1);
  endtask

  task automatic start_read(input logic [31:0] a);
    addr_i = a;
    read_ready_i = 1'b1;
    tick();
    read_ready_i = 1'b0;
  endtask

  initial begin
    int lows;
    int nv0;
    int n;
    // reset state
    repeat (2) tick();
    chk("rst_read", 64'(avm_read_o), 0);
    chk("rst_write", 64'(avm_write_o), 0);
    chk("rst_addr", 64'(avm_address_o), 0);
    chk("rst_wdata", 64'(avm_writedata_o), 0);
    chk("rst_be", 64'(avm_byteenable_o), 0);
    chk("rst_valid", 64'(mem_valid_o), 0);
    chk("rst_rdata", rdata_o, 0);

    // release reset with a read already requested: no bus request in the first cycle
    rst_n = 1'b1;
    addr_i = 32'h100;
    read_ready_i = 1'b1;
    #1;
    chk("post_rst_ready", 64'(mem_ready_o), 1);
    chk("post_rst_noreq", 64'(avm_read_o | avm_write_o), 0);
    tick();
    read_ready_i = 1'b0;
    chk("rd0_req_addr", 64'(avm_address_o), 64'h100);
    wait_valid("rd0");
    chk("rd0_rdata", rdata_o, {32'h1111_1111, 32'h2222_2222});
    chk("rd0_nbeats", 64'(bus_log.size()), 2);
    chk("rd0_addr0", 64'(bus_log[0]), {31'd0, 1'b0, 32'h100});
    chk("rd0_addr1", 64'(bus_log[1]), {31'd0, 1'b0, 32'h104});
    tick();
    chk("rd0_pulse_one", 64'(mem_valid_o), 0);
    chk("rd0_gap_one", 64'(mem_ready_o), 1);
    chk("rd0_npulses", 64'(n_valid), 1);

    // read with waitrequest high for 3 cycles
    clear_logs();
    avm_waitrequest_i = 1'b1;
    start_read(32'h300);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ws_read_c%0d", i), 64'(avm_read_o), 1);
      chk($sformatf("ws_addr_c%0d", i), 64'(avm_address_o), 64'h300);
      if (i == 3) avm_waitrequest_i = 1'b0;
      tick();
    end
    chk("ws_one_accept", 64'(bus_log.size()), 1);
    wait_valid("ws");
    chk("ws_nbeats", 64'(bus_log.size()), 2);
    chk("ws_addr1", 64'(bus_log[1]), {31'd0, 1'b0, 32'h304});
    chk("ws_rdata", rdata_o, {32'hA5A5_A6A5, 32'hA5A5_A6A1});
    tick();

    // line write
    clear_logs();
    addr_i = 32'h200;
    wdata_i = {32'h0000_000A, 32'h0000_000B};
    write_valid_i = 1'b1;
    tick();
    write_valid_i = 1'b0;
    lows = 0;
    while (!mem_ready_o && lows < 20) begin lows++; tick(); end
    chk("wr_ready_low_cycles", 64'(lows), 3);
    chk("wr_nbeats", 64'(bus_log.size()), 2);
    chk("wr_addr0", 64'(bus_log[0]), {31'd0, 1'b1, 32'h200});
    chk("wr_addr1", 64'(bus_log[1]), {31'd0, 1'b1, 32'h204});
    chk("wr_data0", 64'(wdat_log[0]), 64'hA);
    chk("wr_data1", 64'(wdat_log[1]), 64'hB);
    chk("wr_be0", 64'(be_log[0]), 64'hF);
    chk("wr_be1", 64'(be_log[1]), 64'hF);
    chk("wr_rdata_hold", rdata_o, {32'hA5A5_A6A5, 32'hA5A5_A6A1});

    // simultaneous read and write: write first, read after GAP
    clear_logs();
    addr_i = 32'h400;
    wdata_i = {32'h0000_000C, 32'h0000_000D};
    write_valid_i = 1'b1;
    read_ready_i = 1'b1;
    tick();
    write_valid_i = 1'b0;
    addr_i = 32'h500;
    n = 0;
    while (!avm_read_o && n < 20) begin tick(); n++; end
    read_ready_i = 1'b0;
    wait_valid("mix");
    chk("mix_nbeats", 64'(bus_log.size()), 4);
    chk("mix_b0", 64'(bus_log[0]), {31'd0, 1'b1, 32'h400});
    chk("mix_b1", 64'(bus_log[1]), {31'd0, 1'b1, 32'h404});
    chk("mix_b2", 64'(bus_log[2]), {31'd0, 1'b0, 32'h500});
    chk("mix_b3", 64'(bus_log[3]), {31'd0, 1'b0, 32'h504});
    chk("mix_wd", {wdat_log[0], wdat_log[1]}, {32'hC, 32'hD});
    chk("mix_rdata", rdata_o, {32'hA5A5_A0A5, 32'hA5A5_A0A1});
    tick();

    // soft reset while waiting for word 0 data
    clear_logs();
    lat = 3;
    nv0 = n_valid;
    start_read(32'h600);
    tick();
    chk("sr_in_wait", 64'({avm_read_o, mem_ready_o}), 0);
    soft_reset_i = 1'b1;
    repeat (5) tick();
    chk("sr_ready_low", 64'(mem_ready_o), 0);
    chk("sr_data_consumed", 64'(rdv_pend), 0);
    chk("sr_one_read", 64'(bus_log.size()), 1);
    chk("sr_no_pulse", 64'(n_valid - nv0), 0);
    soft_reset_i = 1'b0;
    #1;
    chk("sr_idle", 64'(mem_ready_o), 1);
    chk("sr_rdata_hold", rdata_o, {32'hA5A5_A0A5, 32'hA5A5_A0A1});
    lat = 1;

    // next line starts from word 0 again
    clear_logs();
    start_read(32'h100);
    wait_valid("rd1");
    chk("rd1_addr0", 64'(bus_log[0]), {31'd0, 1'b0, 32'h100});
    chk("rd1_rdata", rdata_o, {32'h1111_1111, 32'h2222_2222});
    tick();

    // address wrap at the top of the space
    clear_logs();
    start_read(32'hFFFF_FFFC);
    wait_valid("wrap");
    chk("wrap_addr0", 64'(bus_log[0]), {31'd0, 1'b0, 32'hFFFF_FFFC});
    chk("wrap_addr1", 64'(bus_log[1]), {31'd0, 1'b0, 32'h0000_0000});
    chk("wrap_rdata", rdata_o, {32'h5A5A_5A59, 32'hA5A5_A5A5});
    tick();

    // stray readdatavalid in IDLE is ignored
    nv0 = n_valid;
    stray_rdv = 1'b1;
    tick();
    stray_rdv = 1'b0;
    tick();
    chk("stray_no_pulse", 64'(n_valid - nv0), 0);
    chk("stray_rdata", rdata_o, {32'h5A5A_5A59, 32'hA5A5_A5A5});
    chk("stray_idle", 64'(mem_ready_o), 1);
    chk("never_rd_and_wr", 64'(n_both), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
